// File: rtl/norm_wb.sv
// rtl/norm_wb.sv - normalized-row write-back: compress, buffer, burst-write to SRAM.
// Define NORM_WB_SAT_EN for unsigned saturation of each word; otherwise words are truncated.
module norm_wb #(
  parameter int col     = 8,
  parameter int bw_psum = 20,
  parameter int bw_out  = 8,
  parameter int depth   = 4,
  parameter int addr_w  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic                     in_valid,
  input  logic [col*bw_psum-1:0]   sfp_in,
  output logic                     in_ready,
  input  logic                     start,
  input  logic [addr_w-1:0]        base_addr,
  input  logic [addr_w:0]          row_count,
  input  logic                     mem_ready,
  output logic                     mem_wen,
  output logic [addr_w-1:0]        mem_addr,
  output logic [col*bw_out-1:0]    mem_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int ptr_w = $clog2(depth) + 1;
  localparam logic [addr_w:0] one_row = 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                  state, state_nx;
  logic [ptr_w-1:0]        wr_ptr, rd_ptr;
  logic [col*bw_out-1:0]   fifo_mem [depth];
  logic [col*bw_out-1:0]   row_c;
  logic                    full, empty, push, pop, drop;
  logic [addr_w-1:0]       addr;
  logic [addr_w:0]         remaining;
  logic                    done_nx;

  // Word-wise compression of the incoming row before it is buffered.
`ifdef NORM_WB_SAT_EN
  always_comb begin
    row_c = '0;
    for (int k = 0; k < col; k++) begin
      if (|sfp_in[bw_psum*k+bw_out +: bw_psum-bw_out])
        row_c[bw_out*k +: bw_out] = '1;
      else
        row_c[bw_out*k +: bw_out] = sfp_in[bw_psum*k +: bw_out];
    end
  end
`else
  logic unused_hi;
  always_comb begin
    row_c     = '0;
    unused_hi = 1'b0;
    for (int k = 0; k < col; k++) begin
      row_c[bw_out*k +: bw_out] = sfp_in[bw_psum*k +: bw_out];
      unused_hi = unused_hi ^ (^sfp_in[bw_psum*k+bw_out +: bw_psum-bw_out]);
    end
  end
`endif

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ptr_w-1] != rd_ptr[ptr_w-1]) &&
                    (wr_ptr[ptr_w-2:0] == rd_ptr[ptr_w-2:0]);
  assign in_ready = !full;

  // A pop frees the slot the same edge, so a push at full is still accepted.
  assign pop  = clk_en && (state == RUN) && !empty && mem_ready;
  assign push = clk_en && in_valid && (!full || pop);
  assign drop = clk_en && in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr[ptr_w-2:0]] <= row_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else if (clk_en) begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (drop)
        overflow <= 1'b1;
      mem_wen <= pop;
      if (pop) begin
        mem_addr <= addr;
        mem_data <= fifo_mem[rd_ptr[ptr_w-2:0]];
      end
      done <= done_nx;
      if (state == IDLE && start) begin
        addr      <= base_addr;
        remaining <= row_count;
      end else if (pop) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else if (clk_en)
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = (row_count == '0) ? FIN : RUN;
      RUN:  if (pop && remaining == one_row) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // done is registered off FIN so it lands one cycle after the last write strobe.
  always_comb begin
    busy    = (state == RUN);
    done_nx = (state == FIN);
  end

endmodule

// File: tb/tb_norm_wb.sv
// tb/tb_norm_wb.sv - self-checking bench for norm_wb against a queue-based row model.
module tb_norm_wb;
  localparam int COL = 8, BWP = 20, BWO = 8, DEPTH = 4, AW = 4;

  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1, in_valid = 1'b0;
  logic start = 1'b0, mem_ready = 1'b0;
  logic [COL*BWP-1:0] sfp_in = '0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] row_count = '0;
  logic in_ready, mem_wen, busy, done, overflow;
  logic [AW-1:0] mem_addr;
  logic [COL*BWO-1:0] mem_data;

  norm_wb dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .sfp_in(sfp_in),
    .in_ready(in_ready), .start(start), .base_addr(base_addr), .row_count(row_count),
    .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0]      a;
    logic [COL*BWO-1:0] d;
    int                 c;
  } wr_t;

  wr_t wq[$];
  int dq[$];
  logic [COL*BWO-1:0] mq[$];
  logic exp_ovf = 1'b0;
  int checks = 0, errors = 0;

  always @(negedge clk) begin
    wr_t w;
    if (!reset) begin
      if (mem_wen) begin
        w.a = mem_addr; w.d = mem_data; w.c = cyc;
        wq.push_back(w);
      end
      if (done) dq.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COL*BWO-1:0] exp_row(input logic [COL*BWP-1:0] row);
    logic [COL*BWO-1:0] r;
    int unsigned w;
    r = '0;
    for (int k = 0; k < COL; k++) begin
      w = 32'(row[k*BWP +: BWP]);
`ifdef NORM_WB_SAT_EN
      r[k*BWO +: BWO] = (w > 255) ? 8'hFF : BWO'(w % 256);
`else
      r[k*BWO +: BWO] = BWO'(w % 256);
`endif
    end
    return r;
  endfunction

  function automatic logic [COL*BWP-1:0] rand_row();
    logic [COL*BWP-1:0] r;
    for (int k = 0; k < COL; k++) begin
      if ($urandom_range(0, 1) == 1) r[k*BWP +: BWP] = BWP'($urandom_range(0, 255));
      else                           r[k*BWP +: BWP] = BWP'($urandom_range(0, (1 << BWP) - 1));
    end
    return r;
  endfunction

  // Push while nothing drains: model keeps at most DEPTH rows, extra rows are lost.
  task automatic push_row(input logic [COL*BWP-1:0] row);
    in_valid = 1'b1; sfp_in = row;
    tick();
    in_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(exp_row(row));
    else exp_ovf = 1'b1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; start = 1'b0; mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mq.delete(); exp_ovf = 1'b0;
    tick();
    wq.delete(); dq.delete();
  endtask

  task automatic begin_burst(input int base, input int cnt, output int n);
    wq.delete(); dq.delete();
    base_addr = AW'(base); row_count = (AW+1)'(cnt); start = 1'b1;
    n = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dq.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(dq.size() != 0), 64'd1);
    repeat (3) tick();
    chk("done_once", 64'(dq.size()), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input int n,
                              input int first_cyc, input int gap);
    logic [COL*BWO-1:0] e;
    chk({tag, "_count"}, 64'(wq.size()), 64'(n));
    for (int i = 0; i < n && i < wq.size(); i++) begin
      e = (mq.size() > 0) ? mq.pop_front() : '0;
      chk({tag, "_addr"}, 64'(wq[i].a), 64'((base + i) % 16));
      chk({tag, "_data"}, 64'(wq[i].d), 64'(e));
      chk({tag, "_cyc"},  64'(wq[i].c), 64'(first_cyc + i * gap));
    end
    chk({tag, "_done_cyc"}, 64'((dq.size() > 0) ? dq[0] : -1),
        64'(first_cyc + (n - 1) * gap + 1));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n;
    logic [COL*BWP-1:0] r;
    logic [COL*BWO-1:0] sat_exp;

    repeat (2) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mem_wen",  64'(mem_wen),  64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_data", 64'(mem_data), 64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;
    tick();

    // basic: three rows, word k = k+1
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < COL; k++) r[k*BWP +: BWP] = BWP'(k + 1);
      push_row(r);
    end
    mem_ready = 1'b1;
    begin_burst(2, 3, n);
    wait_done(20);
    check_writes("basic", 2, 3, n + 2, 1);
    chk("basic_busy_after", 64'(busy), 64'd0);

    // saturation vs truncation
    for (int k = 0; k < COL; k++) r[k*BWP +: BWP] = (k % 2 == 0) ? 20'h00123 : 20'h0007F;
    push_row(r);
`ifdef NORM_WB_SAT_EN
    sat_exp = 64'h7FFF7FFF7FFF7FFF;
`else
    sat_exp = 64'h7F237F237F237F23;
`endif
    begin_burst(7, 1, n);
    wait_done(20);
    chk("sat_word_data", 64'((wq.size() > 0) ? wq[0].d : '0), 64'(sat_exp));
    check_writes("sat", 7, 1, n + 2, 1);

    // backpressure and address wrap
    for (int i = 0; i < 4; i++) push_row(rand_row());
    begin_burst(14, 4, n);
    for (int i = 0; i < 8; i++) begin
      mem_ready = (i % 2 == 0);
      tick();
    end
    wait_done(20);
    check_writes("bp_wrap", 14, 4, n + 2, 2);

    // full and overflow while idle
    for (int i = 0; i < 5; i++) begin
      push_row(rand_row());
      if (i == 2) chk("full_ready_3", 64'(in_ready), 64'd1);
      if (i == 3) chk("full_ready_4", 64'(in_ready), 64'd0);
    end
    chk("ovf_set", 64'(overflow), 64'(exp_ovf));
    mem_ready = 1'b1;
    begin_burst(0, 4, n);
    wait_done(20);
    check_writes("ovf_drain", 0, 4, n + 2, 1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // simultaneous push and pop at full
    do_reset();
    chk("reset_clears_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) push_row(rand_row());
    chk("simul_full", 64'(in_ready), 64'd0);
    mem_ready = 1'b1;
    begin_burst(3, 5, n);
    r = rand_row();
    in_valid = 1'b1; sfp_in = r;
    mq.push_back(exp_row(r));
    tick();
    in_valid = 1'b0;
    chk("simul_no_ovf", 64'(overflow), 64'd0);
    chk("simul_still_full", 64'(in_ready), 64'd0);
    wait_done(20);
    check_writes("simul", 3, 5, n + 2, 1);

    // zero-length burst
    begin_burst(9, 0, n);
    wait_done(20);
    chk("zero_done_cyc", 64'((dq.size() > 0) ? dq[0] : -1), 64'(n + 2));
    chk("zero_no_write", 64'(wq.size()), 64'd0);

    // reset mid-burst
    for (int i = 0; i < 4; i++) push_row(rand_row());
    mem_ready = 1'b1;
    begin_burst(9, 4, n);
    in_valid = 1'b1; sfp_in = rand_row();
    tick();
    in_valid = 1'b0;
    chk("mid_wen_before", 64'(mem_wen), 64'd1);
    chk("mid_busy_before", 64'(busy), 64'd1);
    chk("mid_full_before", 64'(in_ready), 64'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wen", 64'(mem_wen), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    tick();
    reset = 1'b0;
    mq.delete(); exp_ovf = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) push_row(rand_row());
    begin_burst(5, 2, n);
    wait_done(20);
    check_writes("after_rst", 5, 2, n + 2, 1);
    chk("after_rst_ovf", 64'(overflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
